// File: rtl/branch_pkg.sv
// Shared encodings for the branch unit: next-PC select values and 2-bit
// saturating history counter states, plus the counter update function.
package branch_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table of 2-bit saturating counters: one async read port and
// one read-modify-write update port; reset loads every entry as weakly not-taken.
module bht_table
    import branch_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] ctr_q [DEPTH];
    logic [1:0] ctr_d [DEPTH];

    always_comb begin
        ctr_d = ctr_q;
        if (wr_en) ctr_d[wr_idx] = ctr_next(ctr_q[wr_idx], wr_taken);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_WNT;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    // Reads see the registered value, so a same-cycle update shows up next cycle.
    assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/branch_unit.sv
// Decode-stage branch resolution with a fetch-stage predictor and mispredict counter.
// Define BRANCH_UNIT_BHT_EN to build the history table; otherwise prediction is static not-taken.
module branch_unit
    import branch_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int COND_N    = 4,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pred_taken,
    input  logic              id_valid,
    input  logic [PC_W-1:0]   id_pc,
    input  logic              id_pred,
    input  logic [COND_N-1:0] br_type,
    input  logic [COND_N-1:0] cond_met,
    input  logic              j,
    input  logic              jr,
    input  logic              link_req,
    output logic [1:0]        npc_sel,
    output logic              link,
    output logic              flush,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic             is_branch;
    logic             taken;
    npc_sel_e         npc_sel_c;
    logic [CNT_W-1:0] miss_cnt_q;
    logic [CNT_W-1:0] miss_cnt_d;

    assign is_branch = id_valid && (br_type != '0);
    assign taken     = id_valid && ((br_type & cond_met) != '0);

    // Jumps outrank a simultaneously flagged conditional branch.
    always_comb begin
        npc_sel_c = NPC_SEQ;
        if (id_valid && jr)     npc_sel_c = NPC_JR;
        else if (id_valid && j) npc_sel_c = NPC_J;
        else if (taken)         npc_sel_c = NPC_BR;
    end

    assign npc_sel = npc_sel_c;
    assign link    = id_valid && link_req && (j || jr || taken);
    assign flush   = (is_branch && (taken != id_pred)) ||
                     (id_valid && (j || jr) && !id_pred);

    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (!stall && flush && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) miss_cnt_q <= '0;
        else       miss_cnt_q <= miss_cnt_d;
    end

    assign miss_cnt = miss_cnt_q;

`ifdef BRANCH_UNIT_BHT_EN
    logic [1:0] rd_ctr;
    logic       unused_pc_bits;

    bht_table #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (if_pc[IDX_W+1:2]),
        .rd_ctr   (rd_ctr),
        .wr_en    (!stall && is_branch),
        .wr_idx   (id_pc[IDX_W+1:2]),
        .wr_taken (taken)
    );

    assign pred_taken     = rd_ctr[1];
    assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                              id_pc[PC_W-1:IDX_W+2], id_pc[1:0], rd_ctr[0]};
`else
    logic unused_pc_bits;

    assign pred_taken     = 1'b0;
    assign unused_pc_bits = ^{if_pc, id_pc};
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: a reference model pushes expected outputs to a
// scoreboard queue as each step is driven; entries are popped and checked afterwards.
module tb_branch_unit;

`ifdef BRANCH_UNIT_BHT_EN
    localparam bit BHT_EN = 1'b1;
`else
    localparam bit BHT_EN = 1'b0;
`endif

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             stall;
    logic [31:0]      if_pc;
    logic             pred_taken;
    logic             id_valid;
    logic [31:0]      id_pc;
    logic             id_pred;
    logic [3:0]       br_type;
    logic [3:0]       cond_met;
    logic             j;
    logic             jr;
    logic             link_req;
    logic [1:0]       npc_sel;
    logic             link;
    logic             flush;
    logic [CNT_W-1:0] miss_cnt;

    typedef struct {
        string            tag;
        logic             pred;
        logic [1:0]       npc;
        logic             link;
        logic             flush;
        logic [CNT_W-1:0] miss;
    } exp_t;

    exp_t             sb_q[$];
    logic [1:0]       model_bht [16];
    logic [CNT_W-1:0] model_miss;
    logic             model_flush;
    logic             model_taken;
    int               errors = 0;
    int               checks = 0;

    branch_unit #(
        .PC_W      (32),
        .COND_N    (4),
        .BHT_DEPTH (16),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .if_pc      (if_pc),
        .pred_taken (pred_taken),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_pred    (id_pred),
        .br_type    (br_type),
        .cond_met   (cond_met),
        .j          (j),
        .jr         (jr),
        .link_req   (link_req),
        .npc_sel    (npc_sel),
        .link       (link),
        .flush      (flush),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[5:2]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_bht[i] = 2'b01;
        model_miss = '0;
    endtask

    // Drive one set of inputs and queue what the outputs must be.
    task automatic apply_stimulus(input string tag, input logic rst, input logic stl,
                                  input logic [31:0] ipc, input logic v, input logic [31:0] dpc,
                                  input logic prd, input logic [3:0] bt, input logic [3:0] cm,
                                  input logic jj, input logic jjr, input logic lr);
        exp_t e;
        reset = rst; stall = stl; if_pc = ipc; id_valid = v; id_pc = dpc; id_pred = prd;
        br_type = bt; cond_met = cm; j = jj; jr = jjr; link_req = lr;
        if (rst) model_reset();
        model_taken = v && ((bt & cm) != 4'b0);
        model_flush = (v && bt != 4'b0 && (model_taken != prd)) || (v && (jj || jjr) && !prd);
        e.tag   = tag;
        e.pred  = BHT_EN ? model_bht[idx_of(ipc)][1] : 1'b0;
        e.npc   = (v && jjr) ? 2'd3 : (v && jj) ? 2'd2 : model_taken ? 2'd1 : 2'd0;
        e.link  = v && lr && (jj || jjr || model_taken);
        e.flush = model_flush;
        e.miss  = model_miss;
        sb_q.push_back(e);
    endtask

    task automatic check_output();
        exp_t e;
        #1;
        checks++;
        assert (sb_q.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty: observed size 0, expected an entry");
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checks++;
            assert (pred_taken === e.pred) else begin
                errors++;
                $error("FAIL %s.pred_taken: observed %b expected %b", e.tag, pred_taken, e.pred);
            end
            checks++;
            assert (npc_sel === e.npc) else begin
                errors++;
                $error("FAIL %s.npc_sel: observed %0d expected %0d", e.tag, npc_sel, e.npc);
            end
            checks++;
            assert (link === e.link) else begin
                errors++;
                $error("FAIL %s.link: observed %b expected %b", e.tag, link, e.link);
            end
            checks++;
            assert (flush === e.flush) else begin
                errors++;
                $error("FAIL %s.flush: observed %b expected %b", e.tag, flush, e.flush);
            end
            checks++;
            assert (miss_cnt === e.miss) else begin
                errors++;
                $error("FAIL %s.miss_cnt: observed %0d expected %0d", e.tag, miss_cnt, e.miss);
            end
        end
    endtask

    // Advance one edge and move the model the same way the state should move.
    task automatic clock_edge();
        int wi;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (!stall) begin
            wi = idx_of(id_pc);
            if (id_valid && br_type != 4'b0) begin
                if (model_taken && model_bht[wi] != 2'b11) model_bht[wi] = model_bht[wi] + 2'd1;
                if (!model_taken && model_bht[wi] != 2'b00) model_bht[wi] = model_bht[wi] - 2'd1;
            end
            if (model_flush && model_miss != '1) model_miss = model_miss + 1'b1;
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        model_reset();
        // tag, rst, stall, if_pc, valid, id_pc, id_pred, br_type, cond_met, j, jr, link_req
        apply_stimulus("reset", 1, 0, 32'h3000, 0, 32'h0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        check_output();
        clock_edge();

        apply_stimulus("br_taken1", 0, 0, 32'h3004, 1, 32'h3004, 0, 4'b0001, 4'b0001, 0, 0, 0);
        check_output();
        clock_edge();
        apply_stimulus("br_taken2", 0, 0, 32'h3004, 1, 32'h3004, 0, 4'b0001, 4'b0001, 0, 0, 0);
        check_output();
        clock_edge();
        apply_stimulus("idle_pred", 0, 0, 32'h3004, 0, 32'h3004, 0, 4'b0000, 4'b0000, 0, 0, 0);
        check_output();
        clock_edge();

        apply_stimulus("j_jr_link", 0, 0, 32'h3004, 1, 32'h3004, 0, 4'b0000, 4'b0000, 1, 1, 1);
        check_output();
        clock_edge();

        apply_stimulus("br_untaken_link", 0, 0, 32'h3004, 1, 32'h3000, 0, 4'b0010, 4'b0000, 0, 0, 1);
        check_output();
        clock_edge();
        apply_stimulus("floor_step", 0, 0, 32'h3000, 1, 32'h3000, 0, 4'b0100, 4'b0100, 0, 0, 0);
        check_output();
        clock_edge();
        apply_stimulus("same_index", 0, 0, 32'h3000, 1, 32'h3000, 1, 4'b1000, 4'b1000, 0, 0, 0);
        check_output();
        clock_edge();

        apply_stimulus("stall_miss", 0, 1, 32'h3000, 1, 32'h3000, 1, 4'b0001, 4'b0000, 0, 0, 0);
        check_output();
        clock_edge();
        apply_stimulus("after_stall", 0, 0, 32'h3000, 0, 32'h3000, 1, 4'b0000, 4'b0000, 0, 0, 0);
        check_output();
        clock_edge();

        apply_stimulus("j_over_branch", 0, 0, 32'h3008, 1, 32'h3008, 1, 4'b0001, 4'b0001, 1, 0, 0);
        check_output();
        clock_edge();
        apply_stimulus("j_only", 0, 0, 32'h3008, 1, 32'h3010, 1, 4'b0000, 4'b0000, 1, 0, 1);
        check_output();
        clock_edge();
        apply_stimulus("invalid_j", 0, 0, 32'h3008, 0, 32'h3008, 0, 4'b0001, 4'b0001, 1, 0, 1);
        check_output();
        clock_edge();

        for (int k = 0; k < 4; k++) begin
            apply_stimulus($sformatf("jr_sat%0d", k), 0, 0, 32'h3004, 1, 32'h3020, 0,
                           4'b0000, 4'b0000, 0, 1, 0);
            check_output();
            clock_edge();
        end

        #2;
        apply_stimulus("async_reset", 1, 0, 32'h3004, 1, 32'h3004, 0, 4'b0001, 4'b0001, 0, 0, 0);
        check_output();
        clock_edge();
        apply_stimulus("post_reset", 0, 0, 32'h3004, 1, 32'h3004, 1, 4'b0001, 4'b0001, 0, 0, 0);
        check_output();
        clock_edge();
        apply_stimulus("post_reset_up", 0, 0, 32'h3004, 0, 32'h3004, 0, 4'b0000, 4'b0000, 0, 0, 0);
        check_output();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
